// File: rtl/modmul_interleaved_pkg.sv
// Shared types and sizing helpers for the interleaved modular multiplier.
package modmul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEFAULT_W = 8;

    // Width of a counter that indexes bits W-1..0; never narrower than one bit.
    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/modmul_interleaved_cond_sub.sv
// Single modular reduction step: r = (a >= m) ? a - m : a, for a < 2m.
module mod_cond_sub
    import modmul_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] m,
    output logic [W-1:0] r
);

    logic signed [W+1:0] diff;
    logic                diff_unused;

    // The sign bit of the widened difference picks reduced or unreduced value.
    assign diff        = $signed({1'b0, a}) - $signed({2'b00, m});
    assign diff_unused = diff[W];
    assign r           = diff[W+1] ? a[W-1:0] : diff[W-1:0];

endmodule

// File: rtl/modmul_interleaved.sv
// MSB-first interleaved modular multiplier: result = (X*Y) mod Z, 2W+1 cycle latency.
//
// state | meaning
// IDLE  | waiting for start; latches operands and screens for Z==0 or X>=Z
// DBL   | T <= 2T mod Z
// ADD   | T <= (T + X*Y[i]) mod Z, then step i down or finish
// DONE  | one-cycle done pulse, result/err valid
module modmul_interleaved
    import modmul_pkg::*;
#(
    parameter int W  = DEFAULT_W,
    parameter int IW = idx_width(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic [W-1:0] Z,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] result
);

    state_t        state;
    logic [W-1:0]  x_q;
    logic [W-1:0]  y_q;
    logic [W-1:0]  z_q;
    logic [W-1:0]  t;
    logic [IW-1:0] i;

    logic [W:0]    dbl_sum;
    logic [W:0]    add_sum;
    logic [W-1:0]  dbl_t;
    logic [W-1:0]  add_t;
    logic [W-1:0]  add_next;

    assign dbl_sum = {t, 1'b0};
    assign add_sum = {1'b0, t} + {1'b0, x_q};

    mod_cond_sub #(.W(W)) u_dbl (
        .a (dbl_sum),
        .m (z_q),
        .r (dbl_t)
    );

    mod_cond_sub #(.W(W)) u_add (
        .a (add_sum),
        .m (z_q),
        .r (add_t)
    );

    assign add_next = y_q[i] ? add_t : t;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            t      <= '0;
            i      <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q <= X;
                        y_q <= Y;
                        z_q <= Z;
                        t   <= '0;
                        if (Z == '0 || X >= Z) begin
                            err    <= 1'b1;
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            err   <= 1'b0;
                            i     <= IW'(W - 1);
                            state <= DBL;
                        end
                    end
                end
                DBL: begin
                    t     <= dbl_t;
                    state <= ADD;
                end
                ADD: begin
                    t <= add_next;
                    // Result is loaded on entry to DONE so it is valid alongside done.
                    if (i == '0) begin
                        result <= add_next;
                        state  <= DONE;
                    end else begin
                        i     <= i - IW'(1);
                        state <= DBL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
